matrix5x5_linebuf_ctrl: RTL and testbench
=========================================

// Module: matrix5x5_linebuf_ctrl
// PURPOSE
//  Sequencer for the 5x5 line-buffer datapath: four cascaded 1024-deep row FIFOs feeding the 5x5 shift window.
//  - Tracks input pixel and line position.
//  - Drives all FIFO write/read enables.
//  - After the last input line, generates two synthetic flush rows so the bottom two output rows are emitted.
//  - Produces output href/vsync and top/bottom/left/right edge flags, aligned to the window pipeline.
//  - Flags malformed frames.
// PARAMETERS
//  IMG_HDISP  11'd640  active pixels per line (2..1024)
//  IMG_VDISP  11'd480  active lines per frame (>=5)
//  DELAY_NUM  11'd10   idle cycles before each flush row
//  PIPE_DLY   3        output alignment delay in cycles (>=1), matching the window register stages
// PORTS
//  clk                 in   1  system clock
//  rst_n               in   1  asynchronous active-low reset
//  per_img_vsync       in   1  input frame valid, high for the whole frame
//  per_img_href        in   1  input line valid, one pixel per cycle
//  fifo_wen            out  4  write enable, bit k = row FIFO k+1
//  fifo_ren            out  4  read enable, bit k = row FIFO k+1
//  matrix_img_vsync    out  1  output frame valid
//  matrix_img_href     out  1  output window valid
//  matrix_top_edge_flag     out 1  window centre is on output row 0 or 1
//  matrix_bottom_edge_flag  out 1  window centre is on the last 2 rows
//  matrix_left_edge_flag    out 1  window centre is on column 0 or 1
//  matrix_right_edge_flag   out 1  window centre is on column IMG_HDISP-2 or IMG_HDISP-1
//  busy                out  1  FSM not in IDLE
//  frame_err           out  1  one-cycle pulse on a frame format violation
// BEHAVIOUR
//  Reset: all outputs are 0, FSM = IDLE, counters = 0. Reset asserted mid-frame aborts immediately; no flush rows follow.
//  Counters:
//  - hcnt counts href-high cycles and clears when href is low.
//  - vcnt increments on each href falling edge and clears while vsync is low.
//  FSM states and transitions:
//  - IDLE -> FILL on vsync rising edge.
//  - FILL -> STREAM when vcnt reaches 2.
//  - STREAM -> GAP1 on the cycle after the last pixel (vcnt==IMG_VDISP-1, hcnt==IMG_HDISP-1).
//  - GAP1 -> FLUSH1 after DELAY_NUM cycles.
//  - FLUSH1 -> GAP2 after IMG_HDISP cycles.
//  - GAP2 -> FLUSH2 after DELAY_NUM cycles.
//  - FLUSH2 -> IDLE after IMG_HDISP cycles.
//  - A 12-bit state cycle counter times GAP and FLUSH states and clears on every state change.
//  Enables, with h = per_img_href & (state is FILL or STREAM):
//  - fifo_wen[0] = h
//  - fifo_wen[k] = h&(vcnt>k-1) | FLUSH1, for k=1..3
//  - fifo_ren[k] = h&(vcnt>k) | FLUSH1 | FLUSH2, for k=0..3; except fifo_ren[0] excludes FLUSH2
//  Row valid: rv = h&(vcnt>1) | FLUSH1 | FLUSH2.
//  Output timing (every output below is the internal signal delayed exactly PIPE_DLY cycles):
//  - matrix_img_href = rv delayed.
//  - Internal vsync sets on the first pixel of line 2 and clears on the last FLUSH2 cycle; output = that delayed.
//  - Top flag = rv on lines 2-3.
//  - Bottom flag = FLUSH1|FLUSH2.
//  - Left/right flags come from column position: hcnt in STREAM, cycle counter in FLUSH.
//  frame_err pulse, one cycle, on any of these violations:
//  - An href falling edge with hcnt != IMG_HDISP. The line is counted anyway.
//  - vsync falls in FILL/STREAM before line IMG_VDISP completes. FSM -> IDLE with no flush rows; output vsync/href drop after PIPE_DLY.
//  - href or a vsync rising edge seen during GAP/FLUSH. The input is ignored and the flush completes. A new frame is accepted only from IDLE.
//  Simultaneous events: in one cycle, the STREAM->GAP1 transition takes priority over error detection.
// TESTING
//  Use IMG_HDISP=8, IMG_VDISP=6, DELAY_NUM=4, PIPE_DLY=3 unless noted.
//  1 Nominal frame of 6x8 with 2-cycle line gaps:
//    - matrix_img_href has exactly 6 bursts of 8 cycles.
//    - Last two bursts start 4 cycles after the preceding idle.
//    - fifo_wen[0] is high 48 cycles in total; fifo_ren[3] is high 32 cycles in total.
//  2 Edge flags in nominal frame:
//    - Top flag on bursts 1-2 only; bottom flag on bursts 5-6 only.
//    - Left flag on cycles 0-1 of each burst; right flag on cycles 6-7 of each burst.
//  3 vsync dropped after line 3:
//    - One frame_err pulse; busy low within 1 cycle.
//    - No flush bursts; output href/vsync low 3 cycles later.
//  4 Line of 7 pixels in line 2:
//    - One frame_err pulse at the href falling edge.
//    - Frame otherwise completes with 6 output bursts.
//  5 New vsync rising edge during GAP2:
//    - frame_err pulse; flush finishes.
//    - Next frame is accepted only after busy=0.
//  6 rst_n low for 1 cycle during FLUSH1:
//    - All outputs 0 asynchronously; busy=0.
//    - No further href pulses until a fresh vsync.

Source files
------------

// File: rtl/matrix5x5_linebuf_ctrl.sv
// Sequencer for the 5x5 line-buffer window: tracks pixel/line position, drives the
// four row-FIFO enables, appends two flush rows per frame and emits aligned window flags.

module matrix5x5_linebuf_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] DELAY_NUM = 11'd10,
  parameter int          PIPE_DLY  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  output logic [3:0] fifo_wen,
  output logic [3:0] fifo_ren,
  output logic       matrix_img_vsync,
  output logic       matrix_img_href,
  output logic       matrix_top_edge_flag,
  output logic       matrix_bottom_edge_flag,
  output logic       matrix_left_edge_flag,
  output logic       matrix_right_edge_flag,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_GAP1,
    S_FLUSH1,
    S_GAP2,
    S_FLUSH2
  } state_t;

  localparam logic [10:0] H_LAST   = IMG_HDISP - 11'd1;
  localparam logic [10:0] V_LAST   = IMG_VDISP - 11'd1;
  localparam logic [11:0] COL_LAST = {1'b0, H_LAST};
  localparam logic [11:0] COL_RGT  = {1'b0, IMG_HDISP - 11'd2};
  localparam logic [11:0] GAP_LAST = {1'b0, DELAY_NUM - 11'd1};
  localparam logic [10:0] CNT_MAX  = '1;

  state_t                     state_q, state_d;
  logic [10:0]                hcnt_q, hcnt_d;
  logic [10:0]                vcnt_q, vcnt_d;
  logic [11:0]                cyc_q, cyc_d;
  logic                       vsync_q, vsync_d;
  logic                       href_q, href_d;
  logic                       tail_q, tail_d;
  logic                       vs_hold_q, vs_hold_d;
  logic                       err_q, err_d;
  logic [PIPE_DLY-1:0][5:0]   dly_q, dly_d;

  logic        in_frame, in_tail, flush1, flush2, h, rv;
  logic        vs_rise, vs_fall, href_fall, last_pix, tail_err;
  logic        vs_int, top, bottom, left, right;
  logic [11:0] col;

  always_comb begin
    in_frame  = (state_q == S_FILL) || (state_q == S_STREAM);
    flush1    = (state_q == S_FLUSH1);
    flush2    = (state_q == S_FLUSH2);
    in_tail   = (state_q == S_GAP1) || flush1 || (state_q == S_GAP2) || flush2;
    h         = per_img_href && in_frame;
    vs_rise   = per_img_vsync && !vsync_q;
    vs_fall   = !per_img_vsync && vsync_q;
    href_fall = !per_img_href && href_q;
    last_pix  = (state_q == S_STREAM) && per_img_href &&
                (vcnt_q == V_LAST) && (hcnt_q == H_LAST);
    rv        = (h && (vcnt_q > 11'd1)) || flush1 || flush2;
    // An href already high when the tail starts is an over-long last line
    tail_err  = (per_img_href && (!href_q || !tail_q)) || vs_rise;
  end

  always_comb begin
    fifo_wen[0] = h;
    fifo_wen[1] = (h && (vcnt_q > 11'd0)) || flush1;
    fifo_wen[2] = (h && (vcnt_q > 11'd1)) || flush1;
    fifo_wen[3] = (h && (vcnt_q > 11'd2)) || flush1;
    fifo_ren[0] = (h && (vcnt_q > 11'd0)) || flush1;
    fifo_ren[1] = (h && (vcnt_q > 11'd1)) || flush1 || flush2;
    fifo_ren[2] = (h && (vcnt_q > 11'd2)) || flush1 || flush2;
    fifo_ren[3] = (h && (vcnt_q > 11'd3)) || flush1 || flush2;
  end

  always_comb begin
    vsync_d = per_img_vsync;
    href_d  = per_img_href;
    tail_d  = in_tail;
    hcnt_d  = '0;
    if (per_img_href) begin
      hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 11'd1;
    end
    vcnt_d = vcnt_q;
    if (!per_img_vsync) begin
      vcnt_d = '0;
    end else if (href_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 11'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vs_rise) state_d = S_FILL;
      end
      S_FILL, S_STREAM: begin
        if (last_pix) begin
          state_d = S_GAP1;
        end else begin
          if (href_fall && (hcnt_q != IMG_HDISP)) err_d = 1'b1;
          if (vs_fall) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else if ((state_q == S_FILL) && (vcnt_q >= 11'd2)) begin
            state_d = S_STREAM;
          end
        end
      end
      S_GAP1: begin
        err_d = tail_err;
        if (cyc_q == GAP_LAST) state_d = S_FLUSH1;
      end
      S_FLUSH1: begin
        err_d = tail_err;
        if (cyc_q == COL_LAST) state_d = S_GAP2;
      end
      S_GAP2: begin
        err_d = tail_err;
        if (cyc_q == GAP_LAST) state_d = S_FLUSH2;
      end
      S_FLUSH2: begin
        err_d = tail_err;
        if (cyc_q == COL_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cyc_d = in_tail ? cyc_q + 12'd1 : 12'd0;
    if (state_d != state_q) cyc_d = '0;
  end

  // Output frame valid spans from the first window row to the last flush cycle
  always_comb begin
    vs_hold_d = vs_hold_q;
    if (h && (vcnt_q > 11'd1)) vs_hold_d = 1'b1;
    if (state_d == S_IDLE) vs_hold_d = 1'b0;
    vs_int = vs_hold_q || (h && (vcnt_q > 11'd1));
    top    = h && ((vcnt_q == 11'd2) || (vcnt_q == 11'd3));
    bottom = flush1 || flush2;
    col    = (flush1 || flush2) ? cyc_q : {1'b0, hcnt_q};
    left   = rv && (col <= 12'd1);
    right  = rv && (col >= COL_RGT);
    dly_d    = dly_q;
    dly_d[0] = {vs_int, rv, top, bottom, left, right};
    for (int i = 1; i < PIPE_DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // vsync_q resets high so a frame already in progress at reset release is not taken as new
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      cyc_q     <= '0;
      vsync_q   <= 1'b1;
      href_q    <= 1'b0;
      tail_q    <= 1'b0;
      vs_hold_q <= 1'b0;
      err_q     <= 1'b0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      cyc_q     <= cyc_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      tail_q    <= tail_d;
      vs_hold_q <= vs_hold_d;
      err_q     <= err_d;
      dly_q     <= dly_d;
    end
  end

  assign {matrix_img_vsync, matrix_img_href, matrix_top_edge_flag,
          matrix_bottom_edge_flag, matrix_left_edge_flag,
          matrix_right_edge_flag} = dly_q[PIPE_DLY-1];
  assign busy      = (state_q != S_IDLE);
  assign frame_err = err_q;

endmodule

// File: tb/tb_matrix5x5_linebuf_ctrl.sv
// Directed bench for matrix5x5_linebuf_ctrl: table of frame scenarios with expected
// burst/enable/error counts, plus hand-written sequences for abort, reset and re-arm.

module tb_matrix5x5_linebuf_ctrl;

  localparam int HD = 8;
  localparam int PD = 3;

  logic       clk;
  logic       rst_n;
  logic       per_img_vsync;
  logic       per_img_href;
  logic [3:0] fifo_wen;
  logic [3:0] fifo_ren;
  logic       matrix_img_vsync;
  logic       matrix_img_href;
  logic       matrix_top_edge_flag;
  logic       matrix_bottom_edge_flag;
  logic       matrix_left_edge_flag;
  logic       matrix_right_edge_flag;
  logic       busy;
  logic       frame_err;

  matrix5x5_linebuf_ctrl #(
    .IMG_HDISP(11'd8),
    .IMG_VDISP(11'd6),
    .DELAY_NUM(11'd4),
    .PIPE_DLY (PD)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .per_img_vsync          (per_img_vsync),
    .per_img_href           (per_img_href),
    .fifo_wen               (fifo_wen),
    .fifo_ren               (fifo_ren),
    .matrix_img_vsync       (matrix_img_vsync),
    .matrix_img_href        (matrix_img_href),
    .matrix_top_edge_flag   (matrix_top_edge_flag),
    .matrix_bottom_edge_flag(matrix_bottom_edge_flag),
    .matrix_left_edge_flag  (matrix_left_edge_flag),
    .matrix_right_edge_flag (matrix_right_edge_flag),
    .busy                   (busy),
    .frame_err              (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    lines;
    int    short_line;
    int    abort_after;
    int    rst_j;
    int    restart_j;
    int    exp_bursts;
    int    exp_href;
    int    exp_wen0;
    int    exp_ren3;
    int    exp_err;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   bursts, href_cyc, wen0_cnt, ren3_cnt, err_cnt, flag_bad, busy_cnt;
  int   idle_run, pos;
  int   gap_before [8];
  bit   prev_href;
  logic s_busy, s_vsync;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    bursts = 0; href_cyc = 0; wen0_cnt = 0; ren3_cnt = 0; err_cnt = 0;
    flag_bad = 0; busy_cnt = 0; idle_run = 0; pos = 0; prev_href = 1'b0;
    for (int i = 0; i < 8; i++) gap_before[i] = -1;
  endtask

  // Called on the falling edge; the burst index/position model predicts every flag
  task automatic sampleOutputs();
    int b;
    if (matrix_img_href === 1'b1) begin
      if (!prev_href) begin
        if (bursts < 8) gap_before[bursts] = idle_run;
        bursts++;
        pos = 0;
      end
      b = bursts - 1;
      if (matrix_left_edge_flag   !== (pos < 2))      flag_bad++;
      if (matrix_right_edge_flag  !== (pos >= HD - 2)) flag_bad++;
      if (matrix_top_edge_flag    !== (b < 2))        flag_bad++;
      if (matrix_bottom_edge_flag !== (b >= 4))       flag_bad++;
      if (matrix_img_vsync        !== 1'b1)           flag_bad++;
      pos++;
      href_cyc++;
      idle_run = 0;
    end else begin
      idle_run++;
      if (matrix_left_edge_flag || matrix_right_edge_flag ||
          matrix_top_edge_flag || matrix_bottom_edge_flag) flag_bad++;
    end
    if (fifo_wen[0]) wen0_cnt++;
    if (fifo_ren[3]) ren3_cnt++;
    if (frame_err)   err_cnt++;
    if (busy)        busy_cnt++;
    s_busy    = busy;
    s_vsync   = matrix_img_vsync;
    prev_href = (matrix_img_href === 1'b1);
  endtask

  task automatic applyStimulus(input logic vs, input logic hr);
    per_img_vsync = vs;
    per_img_href  = hr;
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input vec_t v);
    int   nl, len;
    bit   done;
    logic vs;
    logic [15:0] all_o;
    clearStats();
    repeat (4) applyStimulus(1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0);
    nl = (v.abort_after >= 0) ? v.abort_after : v.lines;
    for (int l = 0; l < nl; l++) begin
      len = (l == v.short_line) ? HD - 1 : HD;
      repeat (len) applyStimulus(1'b1, 1'b1);
      if ((v.abort_after >= 0) || (l != nl - 1)) repeat (2) applyStimulus(1'b1, 1'b0);
    end
    if (v.abort_after >= 0) begin
      for (int k = 1; k <= 10; k++) begin
        applyStimulus(1'b0, 1'b0);
        if (k == 2) checkOutput({v.name, " busy_after_abort"}, int'(s_busy), 0);
        if (k == 4) checkOutput({v.name, " vsync_before_drop"}, int'(s_vsync), 1);
        if (k == 5) checkOutput({v.name, " vsync_dropped"}, int'(s_vsync), 0);
      end
    end else begin
      done = 1'b0;
      vs   = 1'b0;
      for (int j = 1; (j <= 300) && !done; j++) begin
        vs = (v.restart_j > 0) && (j >= v.restart_j);
        if (j == v.rst_j) begin
          per_img_vsync = vs;
          per_img_href  = 1'b0;
          @(negedge clk);
          sampleOutputs();
          checkOutput({v.name, " busy_before_reset"}, int'(s_busy), 1);
          #2 rst_n = 1'b0;
          #1;
          all_o = {fifo_wen, fifo_ren, matrix_img_vsync, matrix_img_href,
                   matrix_top_edge_flag, matrix_bottom_edge_flag,
                   matrix_left_edge_flag, matrix_right_edge_flag, busy, frame_err};
          checkOutput({v.name, " outputs_in_reset"}, int'(all_o), 0);
          @(negedge clk);
          #2 rst_n = 1'b1;
          @(posedge clk);
          #1;
          done = 1'b1;
        end else begin
          applyStimulus(vs, 1'b0);
          if (!s_busy) done = 1'b1;
        end
      end
      checkOutput({v.name, " busy_release"}, int'(done), 1);
      repeat (PD + 3) applyStimulus(vs, 1'b0);
      if (v.rst_j > 0) repeat (30) applyStimulus(1'b0, 1'b0);
    end
    checkOutput({v.name, " bursts"},    bursts,   v.exp_bursts);
    checkOutput({v.name, " href_cyc"},  href_cyc, v.exp_href);
    checkOutput({v.name, " wen0_cnt"},  wen0_cnt, v.exp_wen0);
    checkOutput({v.name, " ren3_cnt"},  ren3_cnt, v.exp_ren3);
    checkOutput({v.name, " err_cnt"},   err_cnt,  v.exp_err);
    checkOutput({v.name, " flag_bad"},  flag_bad, 0);
    if (v.exp_bursts == 6) begin
      checkOutput({v.name, " gap_flush1"}, gap_before[4], 4);
      checkOutput({v.name, " gap_flush2"}, gap_before[5], 4);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        tbl [6];
    vec_t        rearm;
    logic [15:0] all_o;

    //        name          lines short abort rst restart bursts href wen0 ren3 err
    tbl[0] = '{"nominal",    6,   -1,   -1,   0,  0,      6,     48,  48,  32,  0};
    tbl[1] = '{"short_line", 6,    2,   -1,   0,  0,      6,     47,  47,  32,  1};
    tbl[2] = '{"abort",      6,   -1,    4,   0,  0,      2,     16,  32,   0,  1};
    tbl[3] = '{"reset_fl1",  6,   -1,   -1,   7,  0,      4,     32,  48,  19,  0};
    tbl[4] = '{"after_rst",  6,   -1,   -1,   0,  0,      6,     48,  48,  32,  0};
    tbl[5] = '{"restart_g2", 6,   -1,   -1,   0,  14,     6,     48,  48,  32,  1};

    rst_n         = 1'b0;
    per_img_vsync = 1'b0;
    per_img_href  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    all_o = {fifo_wen, fifo_ren, matrix_img_vsync, matrix_img_href,
             matrix_top_edge_flag, matrix_bottom_edge_flag,
             matrix_left_edge_flag, matrix_right_edge_flag, busy, frame_err};
    checkOutput("reset_state", int'(all_o), 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      $display("[TB] scenario %s", tbl[t].name);
      runFrame(tbl[t]);
    end

    // vsync still high from the restart: lines now must not start a frame
    clearStats();
    repeat (HD) applyStimulus(1'b1, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("stale_vsync busy", busy_cnt, 0);
    checkOutput("stale_vsync href", href_cyc, 0);
    checkOutput("stale_vsync wen0", wen0_cnt, 0);

    rearm      = tbl[0];
    rearm.name = "rearm";
    runFrame(rearm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
